// File: rtl/asip_pipe_pkg.sv
// Shared definitions for the ASIP pipeline stages.
//   pipe_state_e : occupancy state of a 2-entry skid stage (EMPTY/FULL/SKID)
//   PIPE_NOP     : default instruction encoding held by an empty stage slot
//   occ_of()     : number of entries held in a given state
package asip_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

    function automatic logic [1:0] occ_of(input pipe_state_e st);
        case (st)
            ST_FULL: return 2'd1;
            ST_SKID: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register {instr, pc} of a pipeline stage.
//   clock            : rising-edge clock
//   clear            : synchronous clear to {NOP_INSTR, 0}; wins over load
//   load             : capture d_instr/d_pc at the next edge
//   d_instr, d_pc    : payload to capture
//   q_instr, q_pc    : held payload
module pipe_slot
    import asip_pipe_pkg::*;
#(
    parameter int unsigned      IW        = 32,
    parameter int unsigned      AW        = 32,
    parameter logic [IW-1:0]    NOP_INSTR = IW'(PIPE_NOP)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          load,
    input  logic [IW-1:0] d_instr,
    input  logic [AW-1:0] d_pc,
    output logic [IW-1:0] q_instr,
    output logic [AW-1:0] q_pc
);

    logic [IW-1:0] instr_q, instr_d;
    logic [AW-1:0] pc_q, pc_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; holding the current value here is what avoids an inferred latch.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            instr_d = NOP_INSTR;
            pc_d    = '0;
        end else if (load) begin
            instr_d = d_instr;
            pc_d    = d_pc;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so all flops
    // sample their _d values from the same pre-edge snapshot.
    always_ff @(posedge clock) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    assign q_instr = instr_q;
    assign q_pc    = pc_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with a one-entry skid buffer.
// The main slot drives decode; the skid slot catches the single beat that
// arrives in the cycle decode stalls, so in_ready never depends on out_ready.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  : fetch-side handshake; in_instr, in_pc payload
//   out_valid/out_ready: decode-side handshake; out_instr, out_pc payload
//   flush              : drop everything held and the beat offered this cycle
//   occ                : entries held (0..2)
module if_id_skid_stage
    import asip_pipe_pkg::*;
#(
    parameter int unsigned      IW        = 32,
    parameter int unsigned      AW        = 32,
    parameter logic [IW-1:0]    NOP_INSTR = IW'(PIPE_NOP)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    input  logic          flush,
    output logic [1:0]    occ
);

    pipe_state_e   state_q, state_d;

    logic          in_fire;
    logic          main_load, skid_load, main_from_skid, slot_clear;
    logic [IW-1:0] main_instr, skid_instr, main_d_instr;
    logic [AW-1:0] main_pc, skid_pc, main_d_pc;

    // State register; reset outranks flush and every handshake.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // Next-state logic. in_ready already folds in flush and SKID, so in_fire
    // is the true input transfer.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) state_d = ST_FULL;
                ST_FULL: begin
                    if (in_fire && !out_ready)      state_d = ST_SKID;
                    else if (!in_fire && out_ready) state_d = ST_EMPTY;
                end
                ST_SKID:  if (out_ready) state_d = ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Output / slot-control logic.
    always_comb begin
        in_ready       = !reset && !flush && (state_q != ST_SKID);
        out_valid      = (state_q != ST_EMPTY);
        occ            = occ_of(state_q);
        in_fire        = in_valid && in_ready;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: main_load = in_fire;
            ST_FULL: begin
                main_load = in_fire && out_ready;
                skid_load = in_fire && !out_ready;
            end
            ST_SKID: begin
                main_load      = out_ready && !flush;
                main_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    assign slot_clear   = reset || flush;
    assign main_d_instr = main_from_skid ? skid_instr : in_instr;
    assign main_d_pc    = main_from_skid ? skid_pc    : in_pc;

    pipe_slot #(.IW(IW), .AW(AW), .NOP_INSTR(NOP_INSTR)) u_main (
        .clock   (clock),
        .clear   (slot_clear),
        .load    (main_load),
        .d_instr (main_d_instr),
        .d_pc    (main_d_pc),
        .q_instr (main_instr),
        .q_pc    (main_pc)
    );

    pipe_slot #(.IW(IW), .AW(AW), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clock   (clock),
        .clear   (slot_clear),
        .load    (skid_load),
        .d_instr (in_instr),
        .d_pc    (in_pc),
        .q_instr (skid_instr),
        .q_pc    (skid_pc)
    );

    // The main slot is not cleared when its beat drains, so gate the payload
    // with out_valid to present NOP/0 whenever nothing is held.
    assign out_instr = out_valid ? main_instr : NOP_INSTR;
    assign out_pc    = out_valid ? main_pc    : '0;

endmodule

// File: doc/if_id_skid_stage.md
IF_ID_SKID_STAGE -- requirements
Module: if_id_skid_stage

Interface
REQ-001 SHALL have parameter IW, default 32, instruction width in bits.
REQ-002 SHALL have parameter AW, default 32, PC width in bits.
REQ-003 SHALL have parameter NOP_INSTR, default IW'(0), the instruction value driven when no valid beat is held.
REQ-004 SHALL have port clock, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, with reset synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, fetch beat present.
REQ-007 SHALL have port in_ready, output, 1, stage accepts a beat this cycle.
REQ-008 SHALL have port in_instr, input, IW, fetched instruction.
REQ-009 SHALL have port in_pc, input, AW, PC of the fetched instruction.
REQ-010 SHALL have port out_valid, output, 1, decode-side beat present.
REQ-011 SHALL have port out_ready, input, 1, decode consumes the beat this cycle.
REQ-012 SHALL have port out_instr, output, IW, instruction to decode.
REQ-013 SHALL have port out_pc, output, AW, PC to decode.
REQ-014 SHALL have port flush, input, 1, kill all held and incoming beats (branch redirect).
REQ-015 SHALL have port occ, output, 2, entries held (0..2).

Function
REQ-016 SHALL implement a 2-entry skid stage: main slot drives the outputs; skid slot absorbs one beat on back-pressure.
REQ-017 SHALL use three states: EMPTY (occ=0), FULL (occ=1), SKID (occ=2).
REQ-018 A transfer SHALL occur on the input side iff in_valid & in_ready, and on the output side iff out_valid & out_ready.
REQ-019 in_ready SHALL be combinational: 1 in EMPTY/FULL, 0 in SKID, forced 0 while flush=1.
REQ-020 out_valid SHALL be 1 in FULL/SKID and 0 in EMPTY, driven from registered state only.
REQ-021 EMPTY: in_valid -> main<=in, next FULL; otherwise stay.
REQ-022 FULL: in_valid&out_ready -> main<=in, stay FULL; in_valid&!out_ready -> skid<=in, next SKID; !in_valid&out_ready -> next EMPTY; else hold.
REQ-023 SKID: out_ready -> main<=skid, next FULL; else hold both slots; no input is accepted.
REQ-024 Latency SHALL be exactly 1 cycle from input transfer to out_valid with that beat when the stage is EMPTY.
REQ-025 Beats SHALL leave in acceptance order; no beat is duplicated or dropped except by flush.
REQ-026 flush=1 SHALL force the next state to EMPTY regardless of in_valid and out_ready; the incoming beat that cycle is not accepted.
REQ-027 Outputs during the flush cycle SHALL still reflect current state; from the next cycle out_valid=0.
REQ-028 While out_valid=0, out_instr SHALL equal NOP_INSTR and out_pc SHALL equal 0.
REQ-029 While out_valid=1 and out_ready=0, out_instr and out_pc SHALL be stable.

Reset
REQ-030 reset=1 at a rising edge SHALL force state EMPTY, both slots to NOP_INSTR/0, and occ=0.
REQ-031 reset SHALL take priority over flush and every handshake, including mid-SKID.
REQ-032 During reset, in_ready SHALL be 0.

Structure
REQ-033 The state enum (EMPTY/FULL/SKID) SHALL live in shared package asip_pipe_pkg.
REQ-034 The default NOP encoding SHALL be a constant in asip_pipe_pkg, reused by later pipe stages.
REQ-035 Sub-module pipe_slot SHALL be a payload register {instr,pc} with load enable and synchronous clear.
REQ-036 pipe_slot SHALL be instantiated twice, for main and skid.
REQ-037 All sequential logic SHALL be single-edge, nonblocking, clocked by clock only.

Verification
REQ-038 Single beat test: reset, then in_valid=1, instr=0x12345678, pc=0x40 for 1 cycle with out_ready=1 -> next cycle out_valid=1, out_instr=0x12345678, out_pc=0x40; cycle after, out_valid=0, out_instr=NOP.
REQ-039 Back-pressure test: stream A,B,C with out_ready=0 from cycle 1 -> occ 1 then 2; in_ready=0 after B. Raise out_ready -> A, B, C emitted in order, C accepted only once in_ready returns to 1.
REQ-040 Full throughput test: in_valid=out_ready=1 for 8 cycles, instr 1..8 -> out_instr 1..8 on consecutive cycles; occ stays 1.
REQ-041 Flush test: flush=1 in SKID with in_valid=1 -> next cycle occ=0, out_valid=0; the flushed input never appears at the output.
REQ-042 Reset precedence test: assert reset and flush together in SKID -> occ=0, out_pc=0, in_ready=0 during reset; first beat after reset appears with 1-cycle latency.
